hub_link_tx_router: RTL and testbench
=====================================

Name: hub_link_tx_router

Overview:
- Transmit half of the next-generation inter-FPGA hub channel.
- Round-robin arbitrates SRC_COUNT wide message sources (master FIFOs plus stage controller).
- Routes each message by destination FPGA ID to one of FPGA_NEIGHBORS+1 physical lanes.
- Serializes each lane independently, so one busy lane never stalls the others, and gates beats with per-lane credit flow control.

Parameters:
- HUB_FIFO_WIDTH, 32, wide message width; must be an integer multiple of HUB_FIFO_PHYSICAL_WIDTH.
- HUB_FIFO_PHYSICAL_WIDTH, 8, lane beat width.
- FPGAID_WIDTH, 4, destination ID field held in message bits [W-1 : W-FPGAID_WIDTH].
- SRC_COUNT, 9, number of wide sources.
- FPGA_NEIGHBORS, 2, number of neighbour lanes. Lane 0 is the default/local lane.
- CREDIT_WIDTH, 5, credit counter width.
- INIT_CREDITS, 16, credits per lane after reset; must be < 2^CREDIT_WIDTH.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- src_data_vector  in  HUB_FIFO_WIDTH*SRC_COUNT  source messages; source k at slice k.
- src_valid_vector  in  SRC_COUNT  source valid.
- src_ready_vector  out  SRC_COUNT  one-hot grant/pop, combinational.
- fpga_neighbor_array  in  FPGAID_WIDTH*FPGA_NEIGHBORS  FPGA ID for lanes 1..N; slice i-1 holds the ID for lane i.
- lane_data  out  HUB_FIFO_PHYSICAL_WIDTH*(FPGA_NEIGHBORS+1)  beat data per lane.
- lane_valid  out  FPGA_NEIGHBORS+1  beat valid.
- lane_ready  in  FPGA_NEIGHBORS+1  downstream accepts beat.
- credit_return  in  FPGA_NEIGHBORS+1  one-cycle pulse returning one credit.
- credit_overflow  out  FPGA_NEIGHBORS+1  sticky error flag.
- has_flying_messages  out  1  registered activity flag.

Behaviour:
- BEATS = HUB_FIFO_WIDTH/HUB_FIFO_PHYSICAL_WIDTH.
- Lane routing (combinational per source):
  - The destination field is compared against each lane 1..N ID.
  - The lowest-index matching lane wins.
  - No match selects lane 0.
- Arbitration:
  - Source k is eligible when src_valid_vector[k] is high and its routed lane is IDLE.
  - The grant goes to the first eligible source at or after rr_ptr, cyclically.
  - At most one grant per cycle. src_ready_vector[g] is high in the same cycle, and the message is loaded at that edge.
  - rr_ptr <= (g+1) mod SRC_COUNT on grant; unchanged otherwise. Reset value 0.
  - A source whose lane is busy is skipped, not waited on.
- Lane FSM, states IDLE and SEND:
  - IDLE -> SEND on grant: the shift register loads the message and beat_cnt <= 0.
  - In SEND, lane_valid = (credits != 0).
  - Beat order is MSB-first: beat 0 = bits [W-1 : W-P].
  - A beat transfers when lane_valid && lane_ready. The register then shifts left by P and beat_cnt increments.
  - On the transfer of beat BEATS-1, the lane returns to IDLE. The earliest regrant is the next cycle, so per-lane throughput is 1 message per BEATS+1 cycles.
  - lane_data holds stable while lane_valid is high and lane_ready is low.
  - In IDLE, lane_valid = 0 and lane_data = 0.
- Credits, per lane:
  - Reset to INIT_CREDITS.
  - -1 per transferred beat; +1 per credit_return pulse. Both in the same cycle leave the count unchanged.
  - At credits = 0 the lane stalls mid-message with beat_cnt held, and resumes on return.
  - A return while credits = INIT_CREDITS with no simultaneous beat is ignored and sets credit_overflow[i] (sticky until reset).
- has_flying_messages:
  - Registered, reset 0.
  - Next value = |src_valid_vector OR any lane in SEND OR any credits != INIT_CREDITS.
- Reset (async, any time):
  - All lanes go to IDLE, shift registers and beat_cnt clear, credits return to INIT_CREDITS, rr_ptr = 0, flags = 0.
  - A partially sent message is dropped; no recovery beat is emitted.
- Output reset values: src_ready_vector = 0 (no valid sources implies no grant), lane_valid = 0, lane_data = 0, credit_overflow = 0, has_flying_messages = 0.

Test Plan:
1. Single message routed to lane 1. Setup: neighbor_array = 8'h32, source 0 sends 32'h2ABCDEF0, lane_ready = 1. Required: grant in cycle 0; lane1 beats 2A, BC, DE, F0 in cycles 1-4; lane1 credits 16->12; has_flying_messages goes high, then drops once credits are returned.
2. Unmatched ID to default lane. Setup: message 32'h7000_0001. Required: output on lane 0 (beats 70, 00, 00, 01); lanes 1 and 2 stay idle.
3. Round-robin fairness and no cross-lane blocking. Setup: sources 0, 3 and 8 all valid, all targeting lane 2. Required: grants in order 0, 3, 8, one every 5 cycles. Additionally, source 1 targeting lane 1 is granted in the cycle after source 0, while lane 2 is busy.
4. Credit stall. Setup: INIT_CREDITS = 2, one message, no returns. Required: lane_valid drops after 2 beats, with data held; after a credit_return pulse, beat 3 goes out the next cycle.
5. Backpressure plus simultaneous credit return. Setup: lane_ready = 0 for 3 cycles mid-message; also a cycle with beat transfer and credit_return together. Required: lane_data stable while stalled; credit count unchanged in the simultaneous cycle.
6. Reset and overflow. Setup: assert reset during beat 2; separately, pulse credit_return with credits full. Required: lane_valid = 0 immediately on reset, credits = 16, no residual beats; credit_overflow latches 1 and stays set until the next reset.

Source files
------------

// File: rtl/hub_link_tx_router.sv
// Transmit side of the inter-FPGA hub channel: round-robin source arbitration, routing by destination
// FPGA ID, and per-lane MSB-first serialization gated by credit flow control.
module hub_link_tx_router #(
  parameter int HUB_FIFO_WIDTH          = 32,
  parameter int HUB_FIFO_PHYSICAL_WIDTH = 8,
  parameter int FPGAID_WIDTH            = 4,
  parameter int SRC_COUNT               = 9,
  parameter int FPGA_NEIGHBORS          = 2,
  parameter int CREDIT_WIDTH            = 5,
  parameter int INIT_CREDITS            = 16
) (
  input  logic                                                  clk,
  input  logic                                                  reset,
  input  logic [HUB_FIFO_WIDTH*SRC_COUNT-1:0]                   src_data_vector,
  input  logic [SRC_COUNT-1:0]                                  src_valid_vector,
  output logic [SRC_COUNT-1:0]                                  src_ready_vector,
  input  logic [FPGAID_WIDTH*FPGA_NEIGHBORS-1:0]                fpga_neighbor_array,
  output logic [HUB_FIFO_PHYSICAL_WIDTH*(FPGA_NEIGHBORS+1)-1:0] lane_data,
  output logic [FPGA_NEIGHBORS:0]                               lane_valid,
  input  logic [FPGA_NEIGHBORS:0]                               lane_ready,
  input  logic [FPGA_NEIGHBORS:0]                               credit_return,
  output logic [FPGA_NEIGHBORS:0]                               credit_overflow,
  output logic                                                  has_flying_messages
);

  localparam int W     = HUB_FIFO_WIDTH;
  localparam int P     = HUB_FIFO_PHYSICAL_WIDTH;
  localparam int IDW   = FPGAID_WIDTH;
  localparam int LANES = FPGA_NEIGHBORS + 1;
  localparam int BEATS = W / P;
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LSW   = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PTRW  = (SRC_COUNT > 1) ? $clog2(SRC_COUNT) : 1;
  localparam logic [CREDIT_WIDTH-1:0] CRED_INIT = CREDIT_WIDTH'(INIT_CREDITS);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} lane_state_t;

  lane_state_t             state     [LANES];
  lane_state_t             state_nxt [LANES];
  logic [W-1:0]            shreg     [LANES];
  logic [BCW-1:0]          beat_cnt  [LANES];
  logic [CREDIT_WIDTH-1:0] credits   [LANES];
  logic [LSW-1:0]          route     [SRC_COUNT];
  logic [LANES-1:0]        valid;
  logic [LANES-1:0]        xfer;
  logic [LANES-1:0]        last;
  logic [LANES-1:0]        load;
  logic [PTRW-1:0]         rr_ptr;
  logic [PTRW-1:0]         grant_idx;
  logic                    grant_any;
  logic [SRC_COUNT-1:0]    grant_vec;
  logic [W-1:0]            grant_data;
  logic                    fly_nxt;

  // Destination lookup per source; iterating downward lets the lowest matching lane win.
  always_comb begin
    for (int k = 0; k < SRC_COUNT; k++) begin
      route[k] = '0;
      for (int i = FPGA_NEIGHBORS; i >= 1; i--) begin
        route[k] = (src_data_vector[k*W + W - 1 -: IDW] == fpga_neighbor_array[(i-1)*IDW +: IDW])
                   ? LSW'(i) : route[k];
      end
    end
  end

  // Round-robin search from rr_ptr; sources whose lane is busy are skipped.
  always_comb begin : arb
    int              sum;
    logic [PTRW-1:0] cand;
    grant_any = 1'b0;
    grant_idx = '0;
    sum       = 0;
    cand      = '0;
    for (int off = 0; off < SRC_COUNT; off++) begin
      sum  = int'(rr_ptr) + off;
      sum  = (sum >= SRC_COUNT) ? sum - SRC_COUNT : sum;
      cand = PTRW'(sum);
      if (!grant_any && src_valid_vector[cand] && (state[route[cand]] == IDLE)) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end else begin
        grant_any = grant_any;
      end
    end
  end

  // Grant decode: one-hot pop, selected message and the lane it loads into.
  always_comb begin
    grant_vec  = '0;
    grant_data = '0;
    for (int k = 0; k < SRC_COUNT; k++) begin
      if (grant_any && (grant_idx == PTRW'(k))) begin
        grant_vec[k] = 1'b1;
        grant_data   = src_data_vector[k*W +: W];
      end else begin
        grant_vec[k] = 1'b0;
      end
    end
    for (int i = 0; i < LANES; i++) begin
      load[i] = grant_any && (route[grant_idx] == LSW'(i));
    end
  end

  assign src_ready_vector = grant_vec;

  // Lane FSM next state and beat handshake.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      state_nxt[i] = state[i];
      valid[i]     = (state[i] == SEND) && (credits[i] != '0);
      xfer[i]      = valid[i] && lane_ready[i];
      last[i]      = (beat_cnt[i] == BCW'(BEATS - 1));
      case (state[i])
        IDLE:    state_nxt[i] = load[i] ? SEND : IDLE;
        SEND:    state_nxt[i] = (xfer[i] && last[i]) ? IDLE : SEND;
        default: state_nxt[i] = IDLE;
      endcase
    end
  end

  // Lane outputs: the top beat of the shift register while sending, zero when idle.
  always_comb begin
    lane_data  = '0;
    lane_valid = valid;
    for (int i = 0; i < LANES; i++) begin
      lane_data[i*P +: P] = (state[i] == SEND) ? shreg[i][W-1 -: P] : '0;
    end
  end

  // Lane state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LANES; i++) state[i] <= IDLE;
    end else begin
      for (int i = 0; i < LANES; i++) state[i] <= state_nxt[i];
    end
  end

  // Serializer: load on grant, shift left one beat per transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LANES; i++) begin
        shreg[i]    <= '0;
        beat_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (load[i]) begin
          shreg[i]    <= grant_data;
          beat_cnt[i] <= '0;
        end else if (xfer[i]) begin
          shreg[i]    <= shreg[i] << P;
          beat_cnt[i] <= last[i] ? '0 : beat_cnt[i] + BCW'(1);
        end
      end
    end
  end

  // Credit accounting; a return into a full counter is dropped and flagged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LANES; i++) begin
        credits[i]         <= CRED_INIT;
        credit_overflow[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < LANES; i++) begin
        case ({xfer[i], credit_return[i]})
          2'b10: credits[i] <= credits[i] - CREDIT_WIDTH'(1);
          2'b01: begin
            if (credits[i] == CRED_INIT) credit_overflow[i] <= 1'b1;
            else                         credits[i]         <= credits[i] + CREDIT_WIDTH'(1);
          end
          default: credits[i] <= credits[i];
        endcase
      end
    end
  end

  // Activity: pending sources, lanes mid-message, or credits still outstanding.
  always_comb begin
    fly_nxt = |src_valid_vector;
    for (int i = 0; i < LANES; i++) begin
      fly_nxt = fly_nxt | (state[i] == SEND) | (credits[i] != CRED_INIT);
    end
  end

  // Round-robin pointer and registered activity flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr              <= '0;
      has_flying_messages <= 1'b0;
    end else begin
      if (grant_any) begin
        rr_ptr <= (grant_idx == PTRW'(SRC_COUNT - 1)) ? '0 : grant_idx + PTRW'(1);
      end
      has_flying_messages <= fly_nxt;
    end
  end

endmodule

// File: tb/tb_hub_link_tx_router.sv
// Bench for hub_link_tx_router: directed scenarios plus random traffic, checked every cycle
// against a message-level reference model.
module tb_hub_link_tx_router;
  localparam int W = 32, P = 8, IDW = 4, S = 9, N = 2, L = 3, BEATS = 4, INIT = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [W*S-1:0]   src_data;
  logic [S-1:0]     src_valid, src_ready;
  logic [IDW*N-1:0] nbr;
  logic [P*L-1:0]   lane_data;
  logic [L-1:0]     lane_valid, lane_ready, credit_return, credit_overflow;
  logic             flying;

  hub_link_tx_router dut (
    .clk(clk), .reset(reset), .src_data_vector(src_data), .src_valid_vector(src_valid),
    .src_ready_vector(src_ready), .fpga_neighbor_array(nbr), .lane_data(lane_data),
    .lane_valid(lane_valid), .lane_ready(lane_ready), .credit_return(credit_return),
    .credit_overflow(credit_overflow), .has_flying_messages(flying)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  // Reference model: one pending message per lane, beats counted, credits as plain integers.
  bit           m_busy [L];
  logic [W-1:0] m_msg  [L];
  int           m_sent [L];
  int           m_cred [L];
  bit           m_ovf  [L];
  int           m_rr;
  bit           m_fly;
  int           e_g;
  logic [S-1:0] e_ready;
  logic [L-1:0] e_valid;
  logic [P*L-1:0] e_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int dest_lane(input logic [W-1:0] m);
    for (int i = 1; i <= N; i++) if (m[W-1 -: IDW] == nbr[(i-1)*IDW +: IDW]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < L; i++) begin
      m_busy[i] = 0; m_sent[i] = 0; m_cred[i] = INIT; m_ovf[i] = 0; m_msg[i] = '0;
    end
    m_rr = 0; m_fly = 0;
  endtask

  task automatic model_outputs();
    logic [W-1:0] sh;
    e_g = -1;
    for (int off = 0; off < S; off++) begin
      int idx;
      idx = (m_rr + off) % S;
      if (e_g < 0 && src_valid[idx] && !m_busy[dest_lane(src_data[idx*W +: W])]) e_g = idx;
    end
    e_ready = '0;
    if (e_g >= 0) e_ready[e_g] = 1'b1;
    e_data = '0;
    for (int i = 0; i < L; i++) begin
      e_valid[i] = m_busy[i] && (m_cred[i] > 0);
      sh = m_msg[i] >> (P * (BEATS - 1 - m_sent[i]));
      if (m_busy[i]) e_data[i*P +: P] = sh[P-1:0];
    end
  endtask

  task automatic model_advance();
    bit fly_n;
    fly_n = |src_valid;
    for (int i = 0; i < L; i++) fly_n = fly_n | m_busy[i] | (m_cred[i] != INIT);
    for (int i = 0; i < L; i++) begin
      bit x, r;
      x = e_valid[i] && lane_ready[i];
      r = credit_return[i];
      if (x) begin
        m_sent[i]++;
        if (m_sent[i] == BEATS) m_busy[i] = 0;
      end
      if (x && !r) m_cred[i]--;
      else if (r && !x) begin
        if (m_cred[i] == INIT) m_ovf[i] = 1;
        else m_cred[i]++;
      end
    end
    if (e_g >= 0) begin
      int l;
      l = dest_lane(src_data[e_g*W +: W]);
      m_busy[l] = 1; m_msg[l] = src_data[e_g*W +: W]; m_sent[l] = 0;
      m_rr = (e_g + 1) % S;
    end
    m_fly = fly_n;
  endtask

  // One clock: compare everything at the falling edge, then advance the model at the rising edge.
  task automatic tick();
    logic [L-1:0] e_ovf;
    @(negedge clk);
    model_outputs();
    for (int i = 0; i < L; i++) e_ovf[i] = m_ovf[i];
    check("src_ready", src_ready, e_ready);
    check("lane_valid", lane_valid, e_valid);
    check("lane_data", lane_data, e_data);
    check("credit_overflow", credit_overflow, e_ovf);
    check("has_flying", flying, m_fly);
    @(posedge clk);
    if (reset) model_reset();
    else model_advance();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; src_valid = '0; credit_return = '0; lane_ready = '1;
    model_reset();
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic send(input int k, input logic [W-1:0] d);
    bit got;
    got = 0;
    src_data[k*W +: W] = d;
    src_valid[k] = 1'b1;
    for (int c = 0; c < 40 && !got; c++) begin
      #1;
      got = src_ready[k];
      tick();
    end
    src_valid[k] = 1'b0;
    check("send_grant", got, 1);
  endtask

  task automatic wait_idle(input int lane);
    for (int c = 0; c < 60 && m_busy[lane]; c++) tick();
    check("drain_idle", lane_valid[lane], 0);
  endtask

  initial begin
    logic [7:0]   b1 [4];
    logic [7:0]   b2 [4];
    int           gcyc [S];
    logic [S-1:0] g;

    reset = 1'b1; src_data = '0; src_valid = '0; nbr = 8'h32;
    lane_ready = '1; credit_return = '0;
    model_reset();
    #1;
    check("rst_lane_valid", lane_valid, 0);
    check("rst_lane_data", lane_data, 0);
    check("rst_src_ready", src_ready, 0);
    check("rst_overflow", credit_overflow, 0);
    check("rst_flying", flying, 0);
    tick(); tick();
    reset = 1'b0;

    // 1: single message to lane 1
    b1 = '{8'h2A, 8'hBC, 8'hDE, 8'hF0};
    src_data[0 +: W] = 32'h2ABCDEF0; src_valid = 9'h001;
    #1; check("t1_grant", src_ready, 9'h001);
    tick(); src_valid = '0;
    for (int b = 0; b < 4; b++) begin
      #1;
      check("t1_valid", lane_valid, 3'b010);
      check("t1_beat", lane_data[15:8], b1[b]);
      tick();
    end
    #1; check("t1_idle", lane_valid, 0);
    check("t1_flying_hi", flying, 1);
    credit_return[1] = 1'b1; repeat (4) tick(); credit_return[1] = 1'b0;
    tick(); tick();
    #1; check("t1_flying_lo", flying, 0);

    // 2: unmatched ID goes to lane 0
    b2 = '{8'h70, 8'h00, 8'h00, 8'h01};
    src_data[2*W +: W] = 32'h7000_0001; src_valid = 9'h004;
    #1; check("t2_grant", src_ready, 9'h004);
    tick(); src_valid = '0;
    for (int b = 0; b < 4; b++) begin
      #1;
      check("t2_valid", lane_valid, 3'b001);
      check("t2_beat", lane_data[7:0], b2[b]);
      check("t2_others", lane_data[23:8], 0);
      tick();
    end
    credit_return[0] = 1'b1; repeat (4) tick(); credit_return[0] = 1'b0;

    // 3: round robin onto busy lane 2, source 1 on lane 1 not blocked
    do_reset();
    for (int k = 0; k < S; k++) gcyc[k] = -1;
    src_data[0*W +: W] = 32'h3000_0000; src_data[3*W +: W] = 32'h3000_0003;
    src_data[8*W +: W] = 32'h3000_0008; src_data[1*W +: W] = 32'h2000_0001;
    src_valid = 9'b1_0000_1011;
    for (int c = 0; c < 16; c++) begin
      #1;
      g = src_ready;
      for (int k = 0; k < S; k++) if (g[k]) gcyc[k] = c;
      tick();
      src_valid = src_valid & ~g;
    end
    check("t3_src0", gcyc[0], 0);
    check("t3_src1", gcyc[1], 1);
    check("t3_src3", gcyc[3], 5);
    check("t3_src8", gcyc[8], 10);

    // 4: credit stall mid-message (credits brought down to 2 first)
    do_reset();
    send(0, 32'h2111_1111); wait_idle(1);
    credit_return[1] = 1'b1; tick(); tick(); credit_return[1] = 1'b0;
    for (int m = 0; m < 3; m++) begin send(0, 32'h2222_2222); wait_idle(1); end
    send(0, 32'h2A0B_0C0D);
    #1; check("t4_b0", lane_data[15:8], 8'h2A); tick();
    #1; check("t4_b1", lane_data[15:8], 8'h0B); tick();
    for (int c = 0; c < 3; c++) begin
      #1;
      check("t4_stall_valid", lane_valid[1], 0);
      check("t4_stall_data", lane_data[15:8], 8'h0C);
      tick();
    end
    credit_return[1] = 1'b1;
    #1; check("t4_ret_cycle", lane_valid[1], 0); tick();
    credit_return[1] = 1'b0;
    #1; check("t4_resume_valid", lane_valid[1], 1);
    check("t4_resume_data", lane_data[15:8], 8'h0C); tick();

    // 5: backpressure, then transfer and return in the same cycle
    do_reset();
    send(0, 32'h2123_4567);
    #1; check("t5_b0", lane_data[15:8], 8'h21); tick();
    lane_ready[1] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("t5_bp_valid", lane_valid[1], 1);
      check("t5_bp_data", lane_data[15:8], 8'h23);
      tick();
    end
    lane_ready[1] = 1'b1; credit_return[1] = 1'b1;
    #1; check("t5_sim_data", lane_data[15:8], 8'h23); tick();
    credit_return[1] = 1'b0;
    wait_idle(1);
    credit_return[1] = 1'b1; repeat (3) tick(); credit_return[1] = 1'b0;
    tick(); tick();
    #1; check("t5_flying", flying, 0);
    check("t5_no_ovf", credit_overflow, 0);

    // 6: overflow is sticky; reset mid-message drops it
    do_reset();
    credit_return[2] = 1'b1; tick(); credit_return[2] = 1'b0;
    #1; check("t6_ovf_set", credit_overflow, 3'b100);
    repeat (3) tick();
    #1; check("t6_ovf_sticky", credit_overflow, 3'b100);
    send(0, 32'h2055_AAFF); tick(); tick();
    #1; check("t6_pre_valid", lane_valid[1], 1);
    reset = 1'b1; model_reset();
    #1;
    check("t6_rst_valid", lane_valid, 0);
    check("t6_rst_data", lane_data, 0);
    check("t6_rst_ovf", credit_overflow, 0);
    tick(); reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1; check("t6_no_residual", lane_valid, 0);
      tick();
    end

    // Random traffic with occasional ID collisions, spurious returns and resets
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 500 == 0) nbr = {4'($urandom_range(1, 4)), 4'($urandom_range(1, 4))};
      for (int k = 0; k < S; k++) begin
        src_data[k*W +: W] = {4'($urandom_range(0, 5)), 28'($urandom)};
        src_valid[k] = ($urandom_range(0, 2) == 0);
      end
      for (int i = 0; i < L; i++) begin
        lane_ready[i] = ($urandom_range(0, 3) != 0);
        credit_return[i] = (m_cred[i] < INIT) ? ($urandom_range(0, 2) == 0)
                                                : ($urandom_range(0, 63) == 0);
      end
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b1;
        model_reset();
      end
      tick();
      reset = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
